// File: rtl/fp_alu_pkg.sv
// rtl/fp_alu_pkg.sv - shared constants for floating-point ALU arbiters
// Purpose: FSM state encodings, the quiet-NaN abort value and default sizing
// shared by the adder arbiter and any matching divider arbiter.
// Ports: none (package).
package fp_alu_pkg;

  typedef logic [31:0] fp32_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam fp32_t FP_QNAN = 32'h7FC0_0000;

  localparam int DEFAULT_N_REQ   = 4;
  localparam int DEFAULT_TIMEOUT = 64;
  localparam int DEFAULT_CNT_W   = 7;

endpackage

// File: rtl/fp_add_arbiter_if.sv
// rtl/fp_add_arbiter_if.sv - start/valid channel to a shared single-precision adder
// Purpose: bundles the adder handshake so the arbiter and the adder share one port.
// Ports (master = arbiter side):
//   add_start  master->slave  one-cycle start pulse
//   add_in1    master->slave  operand 1, stable from grant until completion
//   add_in2    master->slave  operand 2, stable from grant until completion
//   add_valid  slave->master  one-cycle completion pulse
//   add_result slave->master  sum, meaningful while add_valid=1
interface fp_add_arbiter_if;
  import fp_alu_pkg::*;

  logic  add_start;
  fp32_t add_in1;
  fp32_t add_in2;
  logic  add_valid;
  fp32_t add_result;

  modport master (
    output add_start, add_in1, add_in2,
    input  add_valid, add_result
  );

  modport slave (
    input  add_start, add_in1, add_in2,
    output add_valid, add_result
  );

endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick over a pending vector
// Purpose: returns the first set pending bit at or above rr_ptr, wrapping modulo N_REQ.
// Ports:
//   pending  in   N_REQ  requests waiting for service
//   rr_ptr   in   IDX_W  highest-priority index this round
//   any      out  1      at least one pending bit set
//   grant    out  IDX_W  chosen index (0 when any=0)
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             any,
  output logic [IDX_W-1:0] grant
);

  always_comb begin
    int j;
    j     = 0;
    any   = 1'b0;
    grant = '0;
    // Walk offsets 0..N_REQ-1 from the pointer; the first hit keeps priority.
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) begin
        j = j - N_REQ;
      end
      if (!any && pending[IDX_W'(j)]) begin
        any   = 1'b1;
        grant = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin sharing of one FP adder among N_REQ requesters
// Purpose: latches per-requester start pulses and operands, serialises them onto
// the adder, returns each sum with a one-hot valid pulse, aborts stuck adds.
// Ports:
//   clk, rst    clock (rising edge) and synchronous active-high reset
//   req_start   N_REQ     per-requester start pulse
//   req_in1/2   32*N_REQ  operands, slice i belongs to requester i
//   req_busy    N_REQ     request pending or in flight
//   req_valid   N_REQ     one-hot completion pulse
//   req_error   1         qualifies req_valid: watchdog abort, result is qNaN
//   req_result  32        result of the last completion, held until the next
//   add_bus     master    start/valid channel to the shared adder
module fp_add_arbiter
  import fp_alu_pkg::*;
#(
  parameter int N_REQ   = DEFAULT_N_REQ,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_start,
  input  logic [32*N_REQ-1:0] req_in1,
  input  logic [32*N_REQ-1:0] req_in2,
  output logic [N_REQ-1:0]    req_busy,
  output logic [N_REQ-1:0]    req_valid,
  output logic                req_error,
  output logic [31:0]         req_result,
  fp_add_arbiter_if.master    add_bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [1:0]       state;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] done_mask;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] next_ptr;
  logic [CNT_W-1:0] watchdog;
  logic [31:0]      cap1 [N_REQ];
  logic [31:0]      cap2 [N_REQ];
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             wd_hit;
  logic             finish;

  rr_picker #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_picker (
    .pending(pending),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .grant  (pick_idx)
  );

  // A real completion wins over a watchdog expiry in the same cycle.
  assign wd_hit    = (watchdog == CNT_W'(TIMEOUT - 1));
  assign finish    = (state == ST_WAIT) && (add_bus.add_valid || wd_hit);
  assign done_mask = finish ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant) : '0;
  assign next_ptr  = (grant == IDX_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
  assign req_busy  = pending;

  // Operand capture is deliberately unreset; pending qualifies its contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (req_start[i] && !pending[i]) begin
        cap1[i] <= req_in1[32*i +: 32];
        cap2[i] <= req_in2[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      pending           <= '0;
      rr_ptr            <= '0;
      grant             <= '0;
      watchdog          <= '0;
      req_valid         <= '0;
      req_error         <= 1'b0;
      req_result        <= '0;
      add_bus.add_start <= 1'b0;
      add_bus.add_in1   <= '0;
      add_bus.add_in2   <= '0;
    end else begin
      req_valid <= done_mask;
      req_error <= 1'b0;
      // The completing requester is still pending this cycle, so its own
      // restart is masked; it must re-issue next cycle.
      pending   <= (pending & ~done_mask) | (req_start & ~pending);

      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant           <= pick_idx;
            add_bus.add_in1 <= cap1[pick_idx];
            add_bus.add_in2 <= cap2[pick_idx];
            state           <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          add_bus.add_start <= 1'b1;
          watchdog          <= '0;
          state             <= ST_WAIT;
        end
        ST_WAIT: begin
          add_bus.add_start <= 1'b0;
          if (finish) begin
            req_result <= add_bus.add_valid ? add_bus.add_result : FP_QNAN;
            req_error  <= !add_bus.add_valid;
            rr_ptr     <= next_ptr;
            state      <= ST_IDLE;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - self-checking bench for fp_add_arbiter
module tb_fp_add_arbiter;
  import fp_alu_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_start = '0;
  logic [32*N-1:0] req_in1 = '0;
  logic [32*N-1:0] req_in2 = '0;
  logic [N-1:0]    req_busy;
  logic [N-1:0]    req_valid;
  logic            req_error;
  logic [31:0]     req_result;

  fp_add_arbiter_if bus ();

  fp_add_arbiter #(.N_REQ(N), .TIMEOUT(TMO), .CNT_W(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_start (req_start),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .req_busy  (req_busy),
    .req_valid (req_valid),
    .req_error (req_error),
    .req_result(req_result),
    .add_bus   (bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rr_model = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // IEEE single add through double precision, truncating back (normal inputs only).
  function automatic logic [63:0] to_dbl(input logic [31:0] x);
    logic [10:0] e;
    e = {3'b000, x[30:23]} + 11'd896;
    return {x[31], e, x[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] fp_add_model(input logic [31:0] x, input logic [31:0] y);
    real s;
    logic [63:0] d;
    logic [10:0] e;
    s = $bitstoreal(to_dbl(x)) + $bitstoreal(to_dbl(y));
    d = $realtobits(s);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 149)), 23'($urandom)};
  endfunction

  // Adder model: valid L cycles after the start edge; drops starts on request.
  int adder_lat  = 5;
  int drop_req   = 0;
  int drops_done = 0;
  int acnt       = 0;
  logic [31:0] pend_res;

  always @(posedge clk) begin
    bus.add_valid  <= 1'b0;
    bus.add_result <= $urandom;
    if (bus.add_start) begin
      if (drops_done < drop_req) begin
        drops_done <= drops_done + 1;
      end else begin
        acnt     <= adder_lat - 1;
        pend_res <= fp_add_model(bus.add_in1, bus.add_in2);
      end
    end else if (acnt > 0) begin
      acnt <= acnt - 1;
      if (acnt == 1) begin
        bus.add_valid  <= 1'b1;
        bus.add_result <= pend_res;
      end
    end
  end

  typedef struct {
    logic [N-1:0] vec;
    logic         err;
    logic [31:0]  res;
    logic [31:0]  in1;
    logic [31:0]  in2;
    int           t;
  } comp_t;

  comp_t comp_q[$];

  always @(negedge clk) begin
    if (!rst && req_valid !== '0)
      comp_q.push_back('{req_valid, req_error, req_result, bus.add_in1, bus.add_in2, cyc});
  end

  // Issue one burst and check completions against the round-robin order and timing.
  task automatic run_burst(input logic [N-1:0] mask, input logic [31:0] a[N],
                           input logic [31:0] b[N], input int lat, input int ndrop,
                           input bit repulse);
    int order[$];
    int texp[$];
    int t0, t, n, waited, j;
    logic [N-1:0] ev;
    logic [31:0]  er;
    adder_lat = lat;
    drop_req  = drops_done + ndrop;
    comp_q.delete();
    @(negedge clk);
    req_start = mask;
    for (int i = 0; i < N; i++) begin
      req_in1[32*i +: 32] = a[i];
      req_in2[32*i +: 32] = b[i];
    end
    @(negedge clk);
    t0 = cyc;
    req_start = '0;
    if (repulse) begin
      j = 0;
      for (int i = N - 1; i >= 0; i--) if (mask[i]) j = i;
      req_start[j] = 1'b1;
      req_in1[32*j +: 32] = ~a[j];
      req_in2[32*j +: 32] = ~b[j];
      @(negedge clk);
      req_start = '0;
    end
    for (int k = 0; k < N; k++) begin
      j = (rr_model + k) % N;
      if (mask[j]) order.push_back(j);
    end
    t = t0;
    for (int k = 0; k < order.size(); k++) begin
      t += (k < ndrop) ? (2 + TMO) : (3 + lat);
      texp.push_back(t);
    end
    n = order.size();
    waited = 0;
    while (comp_q.size() < n && waited < texp[n-1] - t0 + 50) begin
      @(negedge clk);
      waited++;
    end
    repeat (2 * (lat + 3)) @(negedge clk);
    total++;
    if (comp_q.size() != n) begin
      bad++;
      $display("FAIL burst_count: got %0d completions, want %0d", comp_q.size(), n);
    end
    for (int k = 0; k < n && k < comp_q.size(); k++) begin
      ev = '0;
      ev[order[k]] = 1'b1;
      er = (k < ndrop) ? FP_QNAN : fp_add_model(a[order[k]], b[order[k]]);
      total++;
      if (comp_q[k].vec !== ev) begin
        bad++; $display("FAIL order[%0d]: req_valid=%b want %b", k, comp_q[k].vec, ev);
      end
      total++;
      if (comp_q[k].err !== 1'(k < ndrop)) begin
        bad++; $display("FAIL error[%0d]: got %b want %b", k, comp_q[k].err, k < ndrop);
      end
      total++;
      if (comp_q[k].res !== er) begin
        bad++; $display("FAIL result[%0d]: got %h want %h", k, comp_q[k].res, er);
      end
      total++;
      if (comp_q[k].in1 !== a[order[k]] || comp_q[k].in2 !== b[order[k]]) begin
        bad++;
        $display("FAIL operands[%0d]: got %h/%h want %h/%h", k, comp_q[k].in1,
                 comp_q[k].in2, a[order[k]], b[order[k]]);
      end
      total++;
      if (comp_q[k].t !== texp[k]) begin
        bad++; $display("FAIL timing[%0d]: edge %0d want %0d", k, comp_q[k].t - t0, texp[k] - t0);
      end
    end
    total++;
    if (req_busy !== '0) begin
      bad++; $display("FAIL busy_after_burst: got %b want 0", req_busy);
    end
    if (n > 0) rr_model = (order[n-1] + 1) % N;
  endtask

  task automatic rand_ops(output logic [31:0] a[N], output logic [31:0] b[N]);
    for (int i = 0; i < N; i++) begin
      a[i] = rand_fp();
      b[i] = rand_fp();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 7;
    if (req_busy !== '0)        begin bad++; $display("FAIL rst_busy: got %b want 0", req_busy); end
    if (req_valid !== '0)       begin bad++; $display("FAIL rst_valid: got %b want 0", req_valid); end
    if (req_error !== 1'b0)     begin bad++; $display("FAIL rst_error: got %b want 0", req_error); end
    if (req_result !== '0)      begin bad++; $display("FAIL rst_result: got %h want 0", req_result); end
    if (bus.add_start !== 1'b0) begin bad++; $display("FAIL rst_add_start: got %b want 0", bus.add_start); end
    if (bus.add_in1 !== '0)     begin bad++; $display("FAIL rst_add_in1: got %h want 0", bus.add_in1); end
    if (bus.add_in2 !== '0)     begin bad++; $display("FAIL rst_add_in2: got %h want 0", bus.add_in2); end
    rst = 1'b0;
    rr_model = 0;
  endtask

  task automatic test_all_four();
    logic [31:0] a[N], b[N];
    rand_ops(a, b);
    run_burst(4'b1111, a, b, 5, 0, 1'b0);
  endtask

  task automatic test_single();
    int t0;
    adder_lat = 5;
    comp_q.delete();
    @(negedge clk);
    req_start = 4'b0010;
    req_in1[63:32] = 32'h3FC0_0000;
    req_in2[63:32] = 32'h4010_0000;
    @(negedge clk);
    t0 = cyc;
    req_start = '0;
    total++;
    if (req_busy !== 4'b0010) begin bad++; $display("FAIL single_busy: got %b want 0010", req_busy); end
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      total++;
      if (bus.add_start !== 1'(e == 2)) begin
        bad++; $display("FAIL single_add_start@%0d: got %b want %b", e, bus.add_start, e == 2);
      end
      total++;
      if (req_valid !== ((e == 8) ? 4'b0010 : 4'b0000)) begin
        bad++; $display("FAIL single_valid@%0d: got %b", e, req_valid);
      end
      if (e >= 8) begin
        total++;
        if (req_result !== 32'h4070_0000) begin
          bad++; $display("FAIL single_result@%0d: got %h want 40700000", e, req_result);
        end
      end
      if (e == 8) begin
        total++;
        if (req_error !== 1'b0) begin bad++; $display("FAIL single_error: got %b want 0", req_error); end
      end
    end
    rr_model = 2;
  endtask

  task automatic test_wrap();
    logic [31:0] a[N], b[N];
    rand_ops(a, b);
    run_burst(4'b0100, a, b, 4, 0, 1'b0);
    rand_ops(a, b);
    run_burst(4'b1001, a, b, 4, 0, 1'b0);
    rand_ops(a, b);
    run_burst(4'b0011, a, b, 3, 0, 1'b0);
  endtask

  task automatic test_busy_restart();
    logic [31:0] a[N], b[N];
    rand_ops(a, b);
    run_burst(4'b0001, a, b, 6, 0, 1'b1);
  endtask

  task automatic test_watchdog();
    logic [31:0] a[N], b[N];
    rand_ops(a, b);
    run_burst(4'b0110, a, b, 5, 1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a[N], b[N];
    for (int r = 0; r < 8; r++) begin
      rand_ops(a, b);
      run_burst(4'($urandom_range(1, 15)), a, b, $urandom_range(2, 8),
                ($urandom_range(0, 3) == 0) ? 1 : 0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a[N], b[N];
    rand_ops(a, b);
    adder_lat = 5;
    @(negedge clk);
    req_start = 4'b0111;
    for (int i = 0; i < N; i++) begin
      req_in1[32*i +: 32] = a[i];
      req_in2[32*i +: 32] = b[i];
    end
    @(negedge clk);
    req_start = '0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total += 5;
    if (req_busy !== '0)        begin bad++; $display("FAIL midrst_busy: got %b want 0", req_busy); end
    if (req_valid !== '0)       begin bad++; $display("FAIL midrst_valid: got %b want 0", req_valid); end
    if (req_result !== '0)      begin bad++; $display("FAIL midrst_result: got %h want 0", req_result); end
    if (bus.add_start !== 1'b0) begin bad++; $display("FAIL midrst_add_start: got %b want 0", bus.add_start); end
    if (bus.add_in1 !== '0)     begin bad++; $display("FAIL midrst_add_in1: got %h want 0", bus.add_in1); end
    rst = 1'b0;
    comp_q.delete();
    repeat (30) @(negedge clk);
    total++;
    if (comp_q.size() != 0) begin
      bad++; $display("FAIL late_valid: got %0d completions want 0", comp_q.size());
    end
    rr_model = 0;
    rand_ops(a, b);
    run_burst(4'b1100, a, b, 5, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_all_four();
    test_single();
    test_wrap();
    test_busy_restart();
    test_watchdog();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
